coherence_bus_ctrl: RTL and testbench

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_bus_ctrl_if.sv | 45 ++++
 rtl/coherence_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the two-core coherence controller, its cores and the RAM.
// Latency: none (wires only).
// Backpressure: cores stall on iwait/dwait; the controller stalls on ramstate.
// Ports: per-core icache (iREN/iaddr/iwait/iload), dcache (dREN/dWEN/daddr/
//        dstore/dwait/dload), coherence (ccwrite/ccwait/ccinv/ccsnoopaddr),
//        and RAM (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate).
interface coherence_bus_ctrl_if #(parameter int CPUS = 2);
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0][31:0]  iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0][31:0]  iload;

    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS-1:0][31:0]  daddr;
    logic [CPUS-1:0][31:0]  dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS-1:0][31:0]  dload;

    logic [CPUS-1:0]        ccwrite;
    logic [CPUS-1:0]        ccwait;
    logic [CPUS-1:0]        ccinv;
    logic [CPUS-1:0][31:0]  ccsnoopaddr;

    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload;
    logic [1:0]             ramstate;

    // master: the bus controller
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    // slave: the cores and the RAM
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates I/D requests onto one RAM, with cache-to-cache transfer.
// Latency: 1 ARB cycle (+1 SNOOP for reads) before the RAM phase; each word completes on ramstate==ACCESS.
// Backpressure: requester held on iwait/dwait=1 until its word completes; RAM BUSY/ERROR stalls in place.
// Ports: CLK, RST (async, active-high), bus (coherence_bus_ctrl_if.master: core I/D/coherence + RAM).
module coherence_bus_ctrl #(
    parameter int CPUS = 2   // only 2 cores are supported
) (
    input  logic                  CLK,
    input  logic                  RST,
    coherence_bus_ctrl_if.master  bus
);
    typedef enum logic [2:0] {IDLE, ARB, SNOOP, C2C, RAMRD, WB, IFETCH, INV} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t state, state_nxt;
    logic   req, req_nxt;        // registered grant: index of the served core
    logic   d_ptr, d_ptr_nxt;    // round-robin priority, data class
    logic   i_ptr, i_ptr_nxt;    // round-robin priority, instruction class
    logic   oth;

    logic [CPUS-1:0] dreq, ireq, vreq;
    logic            word_done, last_word;

    assign oth  = ~req;
    assign dreq = bus.dREN | bus.dWEN;
    assign ireq = bus.iREN;
    // write intent with no accompanying access is a pure invalidate request
    assign vreq = bus.ccwrite & ~dreq;
    // ERROR is deliberately not a completion: it stalls exactly like BUSY
    assign word_done = (bus.ramstate == RAM_ACCESS);
    assign last_word = bus.daddr[req][2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            req   <= 1'b0;
            d_ptr <= 1'b0;
            i_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            req   <= req_nxt;
            d_ptr <= d_ptr_nxt;
            i_ptr <= i_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_nxt         = req;
        d_ptr_nxt       = d_ptr;
        i_ptr_nxt       = i_ptr;
        bus.iwait       = '1;
        bus.iload       = '0;
        bus.dwait       = '1;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;

        case (state)
            IDLE: begin
                if (|dreq || |ireq || |vreq)
                    state_nxt = ARB;
            end

            // Priority: data > instruction > standalone invalidate.
            // Requests that vanished before this cycle are simply dropped.
            ARB: begin
                if (|dreq) begin
                    req_nxt   = dreq[d_ptr] ? d_ptr : ~d_ptr;
                    state_nxt = bus.dWEN[req_nxt] ? WB : SNOOP;
                end else if (|ireq) begin
                    req_nxt   = ireq[i_ptr] ? i_ptr : ~i_ptr;
                    state_nxt = IFETCH;
                end else if (|vreq) begin
                    req_nxt   = vreq[d_ptr] ? d_ptr : ~d_ptr;
                    state_nxt = INV;
                end else begin
                    state_nxt = IDLE;
                end
            end

            // Single snoop cycle ahead of word0; the C2C/RAMRD decision made
            // here holds for both words because word0 loops back to the same state.
            SNOOP: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req];
                bus.ccinv[oth]       = bus.ccwrite[req];
                if (!bus.dREN[req])
                    state_nxt = IDLE;
                else
                    state_nxt = bus.ccwrite[oth] ? C2C : RAMRD;
            end

            // Snooper owns the block: forward its data and write it back to RAM
            // in the same beat so memory is clean afterwards.
            C2C: begin
                if (!bus.dREN[req]) begin
                    state_nxt = IDLE;
                end else begin
                    bus.ccwait[oth] = 1'b1;
                    bus.dload[req]  = bus.dstore[oth];
                    bus.ramWEN      = 1'b1;
                    bus.ramaddr     = bus.daddr[req];
                    bus.ramstore    = bus.dstore[oth];
                    if (word_done) begin
                        bus.dwait[req] = 1'b0;
                        if (last_word) begin
                            state_nxt = IDLE;
                            d_ptr_nxt = ~d_ptr;
                        end
                    end
                end
            end

            RAMRD: begin
                if (!bus.dREN[req]) begin
                    state_nxt = IDLE;
                end else begin
                    bus.ramREN     = 1'b1;
                    bus.ramaddr    = bus.daddr[req];
                    bus.dload[req] = bus.ramload;
                    if (word_done) begin
                        bus.dwait[req] = 1'b0;
                        if (last_word) begin
                            state_nxt = IDLE;
                            d_ptr_nxt = ~d_ptr;
                        end
                    end
                end
            end

            WB: begin
                if (!bus.dWEN[req]) begin
                    state_nxt = IDLE;
                end else begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[req];
                    bus.ramstore = bus.dstore[req];
                    if (word_done) begin
                        bus.dwait[req] = 1'b0;
                        if (last_word) begin
                            state_nxt = IDLE;
                            d_ptr_nxt = ~d_ptr;
                        end
                    end
                end
            end

            IFETCH: begin
                if (!bus.iREN[req]) begin
                    state_nxt = IDLE;
                end else begin
                    bus.ramREN     = 1'b1;
                    bus.ramaddr    = bus.iaddr[req];
                    bus.iload[req] = bus.ramload;
                    if (word_done) begin
                        bus.iwait[req] = 1'b0;
                        state_nxt      = IDLE;
                        i_ptr_nxt      = ~i_ptr;
                    end
                end
            end

            INV: begin
                bus.ccwait[oth]      = 1'b1;
                bus.ccinv[oth]       = 1'b1;
                bus.ccsnoopaddr[oth] = bus.daddr[req];
                state_nxt            = IDLE;
                d_ptr_nxt            = ~d_ptr;
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Testbench for coherence_bus_ctrl: RAM model with fixed latency, directed core
// scenarios, and a scoreboard of completion pulses and RAM writes.
module tb_coherence_bus_ctrl;
    logic CLK;
    logic RST;

    coherence_bus_ctrl_if #(.CPUS(2)) bus();

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // {valid, is_ifetch, core, data}
    logic [34:0] exp_q[$];
    // {valid, addr, data}
    logic [64:0] wr_q[$];
    int snoop_cnt [2];

    localparam int LAT = 2;
    logic [31:0] mem [0:255];
    bit          mem_ready;
    int unsigned ram_cnt;
    bit          err_mode;

    // RAM model: LAT non-ACCESS cycles then one ACCESS cycle per word
    always_comb begin
        if (!(bus.ramREN || bus.ramWEN))
            bus.ramstate = 2'd0;
        else if (ram_cnt == LAT)
            bus.ramstate = 2'd2;
        else
            bus.ramstate = err_mode ? 2'd3 : 2'd1;
        bus.ramload = mem[bus.ramaddr[9:2]];
    end

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= {16'hC0DE, 16'(i)};
            mem[64] <= 32'h0000_AAAA;
            mem[65] <= 32'h0000_BBBB;
            mem_ready <= 1'b1;
        end else if (bus.ramWEN && bus.ramstate == 2'd2) begin
            mem[bus.ramaddr[9:2]] <= bus.ramstore;
        end
        if ((bus.ramREN || bus.ramWEN) && ram_cnt != LAT)
            ram_cnt <= ram_cnt + 1;
        else
            ram_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] pop_exp();
        if (exp_q.size() == 0) return 35'h0;
        return exp_q.pop_front();
    endfunction

    function automatic logic [64:0] pop_wr();
        if (wr_q.size() == 0) return 65'h0;
        return wr_q.pop_front();
    endfunction

    function automatic void push_d(input bit c, input logic [31:0] d);
        exp_q.push_back({1'b1, 1'b0, c, d});
    endfunction

    // Monitor: every completion pulse / RAM write is matched against the scoreboard
    always @(negedge CLK) begin
        if (!RST) begin
            for (int c = 0; c < 2; c++) begin
                if (!bus.dwait[c])
                    chk("dpulse", {1'b1, 1'b0, c[0], bus.dload[c]}, pop_exp());
                if (!bus.iwait[c])
                    chk("ipulse", {1'b1, 1'b1, c[0], bus.iload[c]}, pop_exp());
                if (bus.ccwait[c])
                    snoop_cnt[c]++;
            end
            if (bus.ramWEN && bus.ramstate == 2'd2)
                chk("ramwrite", {1'b1, bus.ramaddr, bus.ramstore}, pop_wr());
            if (bus.ramREN || bus.ramWEN)
                chk("ren_wen_excl", {bus.ramREN, bus.ramWEN} == 2'b11, 0);
        end
    end

    // One core issuing a 2-word data block (read or write)
    task automatic dcore(input int c, input bit wr, input logic [31:0] addr,
                         input logic [31:0] d0, input logic [31:0] d1);
        int words;
        int n;
        words = 0;
        n = 0;
        bus.dREN[c]   = !wr;
        bus.dWEN[c]   = wr;
        bus.daddr[c]  = addr;
        bus.dstore[c] = d0;
        while (words < 2 && n < 300) begin
            @(negedge CLK);
            n++;
            if (!bus.dwait[c]) begin
                words++;
                @(posedge CLK);
                #1;
                bus.daddr[c]  = addr + 32'd4;
                bus.dstore[c] = d1;
            end
        end
        bus.dREN[c] = 1'b0;
        bus.dWEN[c] = 1'b0;
        chk($sformatf("dblock%0d_words", c), words, 2);
    endtask

    task automatic icore(input int c, input logic [31:0] addr);
        int n;
        bit done;
        done = 0;
        bus.iREN[c]  = 1'b1;
        bus.iaddr[c] = addr;
        for (n = 0; n < 300 && !done; n++) begin
            @(negedge CLK);
            if (!bus.iwait[c]) done = 1;
        end
        @(posedge CLK);
        #1;
        bus.iREN[c] = 1'b0;
        chk("ifetch_done", done, 1);
    endtask

    task automatic wait_ccwait(input int c, output bit seen);
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge CLK);
            if (bus.ccwait[c]) seen = 1;
        end
    endtask

    task automatic wait_ramren(output bit seen);
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge CLK);
            if (bus.ramREN) seen = 1;
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, "_pulses_left"}, exp_q.size(), 0);
        chk({tag, "_writes_left"}, wr_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit seen;
        int s0;
        RST         = 1'b1;
        err_mode    = 1'b0;
        bus.iREN    = '0;
        bus.iaddr   = '0;
        bus.dREN    = '0;
        bus.dWEN    = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.ccwrite = '0;

        // reset defaults
        repeat (3) @(negedge CLK);
        chk("rst_iwait", bus.iwait, 2'b11);
        chk("rst_dwait", bus.dwait, 2'b11);
        chk("rst_ram_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        chk("rst_cc", {bus.ccwait, bus.ccinv}, 4'b0000);
        chk("rst_snoopaddr", bus.ccsnoopaddr, 64'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // core0 read block from RAM, RAM reporting ERROR while not ready
        err_mode = 1'b1;
        push_d(0, 32'h0000_AAAA);
        push_d(0, 32'h0000_BBBB);
        s0 = snoop_cnt[1];
        fork
            dcore(0, 0, 32'h100, 32'h0, 32'h0);
            begin
                wait_ccwait(1, seen);
                chk("rd_snoop_seen", seen, 1);
                chk("rd_snoop_inv", bus.ccinv[1], 0);
                chk("rd_snoop_addr", bus.ccsnoopaddr[1], 32'h100);
                chk("rd_no_self_snoop", bus.ccwait[0], 0);
            end
        join
        err_mode = 1'b0;
        chk("rd_snoop_count", snoop_cnt[1] - s0, 1);
        drain("rd");

        // core1 read-for-write, core0 holds block modified: cache-to-cache
        push_d(1, 32'h0000_1234);
        push_d(1, 32'h0000_5678);
        wr_q.push_back({1'b1, 32'h200, 32'h0000_1234});
        wr_q.push_back({1'b1, 32'h204, 32'h0000_5678});
        bus.ccwrite[0] = 1'b1;
        bus.dstore[0]  = 32'h0000_1234;
        bus.ccwrite[1] = 1'b1;
        fork
            begin
                dcore(1, 0, 32'h200, 32'h0, 32'h0);
                bus.ccwrite[1] = 1'b0;
            end
            begin
                int p;
                p = 0;
                wait_ccwait(0, seen);
                chk("c2c_snoop_seen", seen, 1);
                chk("c2c_inv", bus.ccinv[0], 1);
                chk("c2c_snoop_addr", bus.ccsnoopaddr[0], 32'h200);
                chk("c2c_no_self_snoop", bus.ccwait[1], 0);
                for (int n = 0; n < 300 && p < 2; n++) begin
                    @(negedge CLK);
                    if (!bus.dwait[1]) begin
                        p++;
                        @(posedge CLK);
                        #1;
                        if (p == 1) bus.dstore[0] = 32'h0000_5678;
                        else        bus.ccwrite[0] = 1'b0;
                    end
                end
                bus.ccwrite[0] = 1'b0;
            end
        join
        drain("c2c");

        // simultaneous reads after reset: core0 first, then the tie goes to core1
        do_reset();
        push_d(0, 32'h0000_1234);
        push_d(0, 32'h0000_5678);
        push_d(1, 32'h0000_AAAA);
        push_d(1, 32'h0000_BBBB);
        push_d(0, 32'hC0DE_0000);
        push_d(0, 32'hC0DE_0001);
        fork
            begin
                dcore(0, 0, 32'h200, 32'h0, 32'h0);
                dcore(0, 0, 32'h000, 32'h0, 32'h0);
            end
            dcore(1, 0, 32'h100, 32'h0, 32'h0);
        join
        drain("rr");

        // data write beats instruction fetch
        push_d(1, 32'h0);
        push_d(1, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 32'hC0DE_0000});
        wr_q.push_back({1'b1, 32'h300, 32'h0300_AAAA});
        wr_q.push_back({1'b1, 32'h304, 32'h0304_BBBB});
        fork
            icore(0, 32'h0);
            dcore(1, 1, 32'h300, 32'h0300_AAAA, 32'h0304_BBBB);
        join
        drain("wb_if");

        // standalone invalidate from core0
        bus.daddr[0]   = 32'h40;
        bus.ccwrite[0] = 1'b1;
        wait_ccwait(1, seen);
        chk("inv_seen", seen, 1);
        chk("inv_ccinv", bus.ccinv[1], 1);
        chk("inv_addr", bus.ccsnoopaddr[1], 32'h40);
        chk("inv_no_self", bus.ccwait[0], 0);
        @(posedge CLK);
        #1;
        bus.ccwrite[0] = 1'b0;
        @(negedge CLK);
        chk("inv_one_cycle", bus.ccwait[1], 0);
        drain("inv");

        // requester drops strobe mid-word: abort with no completion pulse
        bus.daddr[0] = 32'h100;
        bus.dREN[0]  = 1'b1;
        wait_ramren(seen);
        chk("abort_ramren_seen", seen, 1);
        @(posedge CLK);
        #1;
        bus.dREN[0] = 1'b0;
        @(negedge CLK);
        chk("abort_ramren", bus.ramREN, 0);
        chk("abort_dwait", bus.dwait[0], 1);
        repeat (4) @(negedge CLK);
        drain("abort");

        // reset asserted while RAM read is busy
        bus.daddr[0] = 32'h100;
        bus.dREN[0]  = 1'b1;
        wait_ramren(seen);
        chk("rstmid_ramren_seen", seen, 1);
        chk("rstmid_busy", bus.ramstate, 2'd1);
        RST = 1'b1;
        #1;
        chk("rstmid_ramren_now", bus.ramREN, 0);
        @(negedge CLK);
        chk("rstmid_ramren", bus.ramREN, 0);
        chk("rstmid_dwait", bus.dwait, 2'b11);
        bus.dREN[0] = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        push_d(0, 32'h0000_AAAA);
        push_d(0, 32'h0000_BBBB);
        dcore(0, 0, 32'h100, 32'h0, 32'h0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
